// File: rtl/conv_pkg.sv
// Shared types and defaults for the row loader and the 1-D row convolution stage.
package conv_pkg;

  typedef logic signed [7:0] pixel_t;

  typedef enum logic {
    PAD_ZERO = 1'b0,
    PAD_REPL = 1'b1
  } pad_mode_e;

  localparam int DEF_D = 640;
  localparam int DEF_K = 3;

endpackage

// File: rtl/row_pad_loader_chk.sv
// Occupancy invariants for the ping-pong bank counter.
module row_pad_loader_chk (
  input logic       clk,
  input logic       rst_n,
  input logic [1:0] i_full_cnt,
  input logic       i_close,
  input logic       i_cons
);

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    i_full_cnt != 2'd3);

  a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
    !((i_full_cnt == 2'd0) && i_cons));

  a_no_close_when_full: assert property (@(posedge clk) disable iff (!rst_n)
    !((i_full_cnt == 2'd2) && i_close && !i_cons));

endmodule

// File: rtl/row_pingpong_mem.sv
// Two D-entry pixel banks: one write port with bulk zero-fill above the write index,
// and a parallel read of the whole selected bank.
module row_pingpong_mem
  import conv_pkg::*;
#(
  parameter int D  = DEF_D,
  parameter int AW = (D > 1) ? $clog2(D) : 1
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic          i_wr_bank,
  input  logic [AW-1:0] i_wr_addr,
  input  pixel_t        i_wr_data,
  input  logic          i_clr_above,
  input  logic          i_rd_bank,
  output pixel_t        o_rd_row [D]
);

  pixel_t r_mem [2][D];

  // Contents are deliberately not reset; a short row zero-fills its own tail.
  always_ff @(posedge clk) begin
    for (int i = 0; i < D; i++) begin
      if (i_we && (i == int'(i_wr_addr))) begin
        r_mem[i_wr_bank][i] <= i_wr_data;
      end else if (i_we && i_clr_above && (i > int'(i_wr_addr))) begin
        r_mem[i_wr_bank][i] <= pixel_t'(8'sd0);
      end
    end
  end

  for (genvar g = 0; g < D; g++) begin : g_rd
    assign o_rd_row[g] = r_mem[i_rd_bank][g];
  end

endmodule

// File: rtl/row_pad_loader.sv
// Serial pixel stream to padded parallel row, double-buffered through two banks.
// Short rows are zero-filled, long rows are truncated and their excess beats dropped.
module row_pad_loader
  import conv_pkg::*;
#(
  parameter int D        = DEF_D,
  parameter int K        = DEF_K,
  parameter int PAD_MODE = 0
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   s_valid,
  output logic   s_ready,
  input  pixel_t s_data,
  input  logic   s_last,
  output logic   m_valid,
  input  logic   m_ready,
  output pixel_t m_row [D+2*K],
  output logic   err_short,
  output logic   err_long
);

  localparam int CW = (D > 1) ? $clog2(D) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(D - 1);
  localparam logic [0:0] ST_FILL = 1'b0;
  localparam logic [0:0] ST_DROP = 1'b1;
  localparam pad_mode_e MODE = (PAD_MODE == 1) ? PAD_REPL : PAD_ZERO;

  logic [0:0]    r_state;
  logic [CW-1:0] r_col;
  logic [1:0]    r_full_cnt;
  logic          r_wr;
  logic          r_rd;
  logic          r_s_ready;
  logic          r_err_short;
  logic          r_err_long;

  logic          w_acc;
  logic          w_cons;
  logic          w_fill_acc;
  logic          w_at_end;
  logic          w_close;
  logic          w_short;
  logic          w_long_start;
  logic          w_long_end;
  logic [1:0]    w_cnt_nxt;
  logic [0:0]    w_state_nxt;
  logic [CW-1:0] w_col_nxt;
  pixel_t        w_rd_row [D];
  pixel_t        w_lpad;
  pixel_t        w_rpad;

  assign m_valid   = (r_full_cnt != 2'd0);
  assign s_ready   = r_s_ready;
  assign err_short = r_err_short;
  assign err_long  = r_err_long;

  assign w_acc        = s_valid && r_s_ready;
  assign w_cons       = m_valid && m_ready;
  assign w_fill_acc   = w_acc && (r_state == ST_FILL);
  assign w_at_end     = (r_col == COL_LAST);
  assign w_close      = w_fill_acc && (w_at_end || s_last);
  assign w_short      = w_fill_acc && s_last && !w_at_end;
  assign w_long_start = w_fill_acc && w_at_end && !s_last;
  assign w_long_end   = w_acc && (r_state == ST_DROP) && s_last;

  // Next-state terms; a close and a consume in one cycle cancel out.
  always_comb begin
    w_cnt_nxt = r_full_cnt;
    case ({w_close, w_cons})
      2'b10:   w_cnt_nxt = r_full_cnt + 2'd1;
      2'b01:   w_cnt_nxt = r_full_cnt - 2'd1;
      default: w_cnt_nxt = r_full_cnt;
    endcase
    if (w_long_start) begin
      w_state_nxt = ST_DROP;
    end else if (w_long_end) begin
      w_state_nxt = ST_FILL;
    end else begin
      w_state_nxt = r_state;
    end
    if (w_close) begin
      w_col_nxt = '0;
    end else if (w_fill_acc) begin
      w_col_nxt = r_col + CW'(1);
    end else begin
      w_col_nxt = r_col;
    end
  end

  // s_ready is registered from next-state values, so m_ready never reaches it combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_FILL;
      r_col       <= '0;
      r_full_cnt  <= 2'd0;
      r_wr        <= 1'b0;
      r_rd        <= 1'b0;
      r_s_ready   <= 1'b0;
      r_err_short <= 1'b0;
      r_err_long  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_col       <= w_col_nxt;
      r_full_cnt  <= w_cnt_nxt;
      r_wr        <= r_wr ^ w_close;
      r_rd        <= r_rd ^ w_cons;
      r_s_ready   <= (w_state_nxt == ST_DROP) || (w_cnt_nxt != 2'd2);
      r_err_short <= w_short;
      r_err_long  <= w_long_end;
    end
  end

  row_pingpong_mem #(.D(D), .AW(CW)) u_mem (
    .clk         (clk),
    .i_we        (w_fill_acc),
    .i_wr_bank   (r_wr),
    .i_wr_addr   (r_col),
    .i_wr_data   (s_data),
    .i_clr_above (w_short),
    .i_rd_bank   (r_rd),
    .o_rd_row    (w_rd_row)
  );

  assign w_lpad = (MODE == PAD_REPL) ? w_rd_row[0]   : pixel_t'(8'sd0);
  assign w_rpad = (MODE == PAD_REPL) ? w_rd_row[D-1] : pixel_t'(8'sd0);

  for (genvar g = 0; g < D + 2*K; g++) begin : g_pad
    if (g < K) begin : g_left
      assign m_row[g] = w_lpad;
    end else if (g < D + K) begin : g_mid
      assign m_row[g] = w_rd_row[g-K];
    end else begin : g_right
      assign m_row[g] = w_rpad;
    end
  end

  row_pad_loader_chk u_chk (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_full_cnt (r_full_cnt),
    .i_close    (w_close),
    .i_cons     (w_cons)
  );

endmodule

// File: tb/tb_row_pad_loader.sv
// Randomized bench for row_pad_loader (zero-pad and replicate instances side by side)
// against a row-level queue model of the loader.
module tb_row_pad_loader;
  import conv_pkg::*;

  localparam int D = 8;
  localparam int K = 3;
  localparam int W = D + 2*K;

  logic   clk = 1'b0;
  logic   rst_n = 1'b0;
  logic   s_valid = 1'b0;
  pixel_t s_data = '0;
  logic   s_last = 1'b0;
  logic   m_ready = 1'b0;

  logic   s_ready_z, m_valid_z, err_short_z, err_long_z;
  logic   s_ready_r, m_valid_r, err_short_r, err_long_r;
  pixel_t m_row_z [W];
  pixel_t m_row_r [W];
  logic [8*W-1:0] row_z_p, row_r_p;

  always #5 clk = ~clk;

  row_pad_loader #(.D(D), .K(K), .PAD_MODE(0)) u_dut_zero (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready_z), .s_data(s_data),
    .s_last(s_last), .m_valid(m_valid_z), .m_ready(m_ready), .m_row(m_row_z),
    .err_short(err_short_z), .err_long(err_long_z));

  row_pad_loader #(.D(D), .K(K), .PAD_MODE(1)) u_dut_repl (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready_r), .s_data(s_data),
    .s_last(s_last), .m_valid(m_valid_r), .m_ready(m_ready), .m_row(m_row_r),
    .err_short(err_short_r), .err_long(err_long_r));

  always_comb begin
    row_z_p = '0;
    row_r_p = '0;
    for (int i = 0; i < W; i++) begin
      row_z_p[8*i +: 8] = m_row_z[i];
      row_r_p[8*i +: 8] = m_row_r[i];
    end
  end

  int total = 0;
  int bad = 0;
  int vprob = 100;
  int rprob = 0;

  logic [8:0]     beats_q [$];
  logic [8*D-1:0] rows_q [$];
  logic [8*D-1:0] cur;
  int             cur_n;
  bit             drop;
  bit             exp_s_ready, exp_err_s, exp_err_l;

  task automatic chk(input string tag, input logic [8*W-1:0] obs, input logic [8*W-1:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [8*W-1:0] expand(input logic [8*D-1:0] r, input bit repl);
    logic [8*W-1:0] o;
    o = '0;
    for (int i = 0; i < W; i++) begin
      if (i < K)          o[8*i +: 8] = repl ? r[7:0] : 8'h00;
      else if (i < D + K) o[8*i +: 8] = r[8*(i-K) +: 8];
      else                o[8*i +: 8] = repl ? r[8*(D-1) +: 8] : 8'h00;
    end
    return o;
  endfunction

  task automatic model_reset();
    rows_q.delete();
    beats_q.delete();
    cur = '0;
    cur_n = 0;
    drop = 1'b0;
    exp_s_ready = 1'b0;
    exp_err_s = 1'b0;
    exp_err_l = 1'b0;
  endtask

  task automatic model_update(input bit acc, input bit cons, input logic [7:0] d, input bit last);
    exp_err_s = 1'b0;
    exp_err_l = 1'b0;
    if (cons) void'(rows_q.pop_front());
    if (acc) begin
      if (drop) begin
        if (last) begin
          drop = 1'b0;
          exp_err_l = 1'b1;
        end
      end else begin
        cur[8*cur_n +: 8] = d;
        cur_n++;
        if (cur_n == D) begin
          rows_q.push_back(cur);
          cur = '0;
          cur_n = 0;
          if (!last) drop = 1'b1;
        end else if (last) begin
          rows_q.push_back(cur);
          cur = '0;
          cur_n = 0;
          exp_err_s = 1'b1;
        end
      end
    end
    exp_s_ready = drop || (rows_q.size() < 2);
  endtask

  task automatic check_outputs();
    bit exp_mv;
    exp_mv = (rows_q.size() > 0);
    chk("m_valid_z", m_valid_z, exp_mv);
    chk("m_valid_r", m_valid_r, exp_mv);
    chk("s_ready_z", s_ready_z, exp_s_ready);
    chk("s_ready_r", s_ready_r, exp_s_ready);
    chk("err_short", err_short_z, exp_err_s);
    chk("err_long", err_long_z, exp_err_l);
    chk("err_short_r", err_short_r, exp_err_s);
    chk("err_long_r", err_long_r, exp_err_l);
    if (exp_mv) begin
      chk("row_zero", row_z_p, expand(rows_q[0], 1'b0));
      chk("row_repl", row_r_p, expand(rows_q[0], 1'b1));
    end
  endtask

  // One clock: drive at the falling edge, check, then advance the model at the rising edge.
  task automatic tick();
    bit acc, cons;
    if ((beats_q.size() > 0) && ($urandom_range(99) < vprob)) begin
      s_valid = 1'b1;
      {s_last, s_data} = beats_q[0];
    end else begin
      s_valid = 1'b0;
      s_data = pixel_t'($urandom);
      s_last = 1'($urandom);
    end
    m_ready = ($urandom_range(99) < rprob);
    check_outputs();
    acc  = s_valid && exp_s_ready && rst_n;
    cons = (rows_q.size() > 0) && m_ready && rst_n;
    @(posedge clk);
    if (rst_n) model_update(acc, cons, s_data, s_last);
    if (acc) void'(beats_q.pop_front());
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic drain(input int bound);
    int n;
    n = 0;
    while (((beats_q.size() > 0) || (rows_q.size() > 0)) && (n < bound)) begin
      tick();
      n++;
    end
    chk("drain_timeout", n < bound, 1'b1);
  endtask

  task automatic push_row(input int start, input int n);
    for (int i = 0; i < n; i++) beats_q.push_back({(i == n - 1), 8'(start + i)});
  endtask

  task automatic push_rand_row(input int n);
    for (int i = 0; i < n; i++) beats_q.push_back({(i == n - 1), 8'($urandom)});
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_m_valid_z", m_valid_z, 1'b0);
    chk("rst_m_valid_r", m_valid_r, 1'b0);
    model_reset();
    @(negedge clk);
    run(2);
    rst_n = 1'b1;
  endtask

  logic [8*W-1:0] lit_z, lit_r;

  initial begin
    @(negedge clk);
    do_reset();

    // Row 1..8 held so its padded form can be compared to literal values.
    vprob = 100; rprob = 0;
    push_row(1, 8);
    run(12);
    lit_z = '0;
    lit_r = '0;
    for (int i = 0; i < W; i++) begin
      lit_z[8*i +: 8] = (i >= K && i < D + K) ? 8'(i - K + 1) : 8'd0;
      lit_r[8*i +: 8] = (i < K) ? 8'd1 : (i < D + K) ? 8'(i - K + 1) : 8'd8;
    end
    chk("first_row_zero", row_z_p, lit_z);
    chk("first_row_repl", row_r_p, lit_r);
    rprob = 100;
    drain(40);

    push_row(10, 8);
    rprob = 50;
    drain(60);

    // Consumer stalled: A and B fill both banks, the third row must wait.
    rprob = 0;
    push_row(1, 8);
    push_row(21, 8);
    push_row(41, 8);
    run(30);
    chk("stall_s_ready", s_ready_z, 1'b0);
    rprob = 100;
    run(1);
    rprob = 0;
    run(20);
    rprob = 100;
    drain(60);

    push_row(5, 3);
    drain(40);

    push_row(1, 11);
    push_row(51, 8);
    rprob = 40;
    drain(80);

    // Reset with one bank pending and a row half-written.
    rprob = 0;
    push_row(1, 8);
    run(10);
    push_row(31, 8);
    run(4);
    do_reset();
    push_row(1, 8);
    rprob = 100;
    drain(40);

    // Random rows of short, exact and long length with random backpressure.
    vprob = 70; rprob = 60;
    for (int r = 0; r < 40; r++) push_rand_row($urandom_range(1, 12));
    drain(3000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
